booth_mul_arbiter: RTL and testbench
====================================

# booth_mul_arbiter

Shares one sequential Booth radix-4 multiplier between NREQ independent requesters. Each requester presents signed operand pairs over a valid/ready handshake. The block grants round-robin, issues a one-cycle start pulse to the shared multiplier, and waits for its done strobe with a watchdog. It then returns the 2W-bit product, tagged with the requester ID, over a valid/ready response channel. It sits between the processing clients and the single multiplier instance.

## Interface
- NREQ, 4, number of requesters (2..8)
- W, 16, operand width; product is 2W
- TIMEOUT, 32, max WAIT cycles before abort (>=2)
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- req_valid  in  NREQ  per-requester request valid
- req_ready  out  NREQ  per-requester accept; one-hot or zero
- req_x  in  NREQ*W  flattened multiplicands, requester i at [i*W +: W]
- req_y  in  NREQ*W  flattened multipliers, same packing
- mul_start  out  1  one-cycle start pulse to multiplier
- mul_x, mul_y  out  W each  latched operands to multiplier, stable from ISSUE until return to IDLE
- mul_done  in  1  multiplier result-valid strobe
- mul_out  in  2W  multiplier product
- rsp_valid  out  1  response valid
- rsp_ready  in  1  consumer accept
- rsp_id  out  $clog2(NREQ)  requester index of response
- rsp_data  out  2W  product, or 0 on error
- rsp_err  out  1  1 = watchdog timeout

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: the round-robin arbiter picks the first valid requester at or after pointer ptr, wrapping modulo NREQ. req_ready[g]=1 for the granted requester only (combinational, IDLE only). On handshake, latch req_x[g]/req_y[g] and g, set ptr=g+1 mod NREQ, go to ISSUE. No valid requester: stay in IDLE, ptr unchanged.
- ISSUE: mul_start=1 for exactly this cycle. Clear the watchdog counter. Go to WAIT.
- WAIT: the counter increments each cycle.
  - mul_done=1: latch mul_out into rsp_data, rsp_err=0, go to RESP.
  - Otherwise, counter reaching TIMEOUT: rsp_data=0, rsp_err=1, go to RESP.
  - mul_done and timeout in the same cycle: done wins.
- RESP: rsp_valid=1. rsp_id, rsp_data and rsp_err are held stable until rsp_ready=1, then go to IDLE. No new grant while in RESP.
- mul_done outside WAIT is ignored, including a late done after a timeout.
- Operands are passed through unmodified. Signedness is the multiplier's concern.
- Reset at any time:
  - state=IDLE, ptr=0, counter=0.
  - All outputs 0: req_ready, mul_start, mul_x, mul_y, rsp_valid, rsp_id, rsp_data, rsp_err.
  - Any in-flight operation is discarded with no response.

## Timing
- The accept handshake occurs in cycle T0 (IDLE).
- mul_start is high in T0+1.
- If the multiplier asserts mul_done in cycle T0+1+L (L>=1), rsp_valid rises in T0+2+L.
- Throughput is one operation per L+3 cycles minimum with rsp_ready held high. RESP->IDLE costs one cycle before the next grant.
- On timeout, rsp_valid rises in T0+2+TIMEOUT.
- All outputs except req_ready are registered. req_ready is combinational from state, ptr and req_valid.
- Backpressure: rsp_ready low holds RESP indefinitely; all requesters see req_ready=0.

## Structure
- Package booth_arb_pkg holds:
  - state enum (IDLE, ISSUE, WAIT, RESP), 2-bit encoding;
  - ID width constant, defined as $clog2 of NREQ;
  - default TIMEOUT constant.
- Sub-module rr_arbiter: purely combinational. Inputs are the req vector and ptr; outputs are a one-hot grant plus the encoded index. Parameterised on NREQ and reusable for other shared units.
- Top holds the FSM, the operand/ID/result registers, ptr and the watchdog counter.

## Test plan
- Single request: requester 2 sends x=0x0003, y=0x0004; multiplier model with L=8 -> rsp_valid at T0+10, rsp_id=2, rsp_data=0x0000000C, rsp_err=0.
- Signed pass-through: x=0xFFFD (-3), y=0x0004 -> mul_x/mul_y carry exactly 0xFFFD/0x0004, rsp_data=0xFFFFFFF4.
- Fairness: all 4 requesters valid continuously -> grant order 0,1,2,3,0. Then drop requester 1 -> order skips 1 and ptr wraps correctly.
- Timeout: model never asserts done, TIMEOUT=32 -> rsp_err=1, rsp_data=0 at T0+34. A late mul_done afterwards produces no second response.
- Backpressure: hold rsp_ready=0 for 20 cycles with other requesters valid -> rsp fields stable, req_ready all 0, no mul_start.
- Reset mid-WAIT: assert reset during WAIT -> all outputs 0 immediately. After release, the first grant goes to requester 0 and no stale response appears.

Source files
------------

// File: rtl/booth_arb_pkg.sv
// Shared types and defaults for the Booth multiplier arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package booth_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_e;

    localparam int NREQ_DEFAULT    = 4;
    localparam int ID_W            = $clog2(NREQ_DEFAULT);
    localparam int TIMEOUT_DEFAULT = 32;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin picker: first asserted request at or after ptr, wrapping modulo NREQ.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the grant is consumed.
module rr_arbiter
    import booth_arb_pkg::*;
#(
    parameter int NREQ = NREQ_DEFAULT,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IDW-1:0]  ptr_i,
    output logic [NREQ-1:0] gnt_o,
    output logic [IDW-1:0]  idx_o,
    output logic            vld_o
);

    int             cand;
    logic [IDW-1:0] cidx;

    // Walk from the farthest offset back to ptr so the nearest hit is the last write.
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        vld_o = 1'b0;
        cand  = 0;
        cidx  = '0;
        for (int off = NREQ - 1; off >= 0; off--) begin
            cand = int'(ptr_i) + off;
            if (cand >= NREQ) begin
                cand = cand - NREQ;
            end
            cidx = cand[IDW-1:0];
            if (req_i[cidx]) begin
                gnt_o       = '0;
                gnt_o[cidx] = 1'b1;
                idx_o       = cidx;
                vld_o       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/booth_mul_arbiter.sv
// Shares one sequential Booth multiplier among NREQ requesters, round-robin, with a done watchdog.
// Latency: accept T0, start T0+1, response T0+2+L (or T0+2+TIMEOUT on abort).
// Backpressure: rsp_ready low holds RESP and blocks all new grants.
module booth_mul_arbiter
    import booth_arb_pkg::*;
#(
    parameter int NREQ    = NREQ_DEFAULT,
    parameter int W       = 16,
    parameter int TIMEOUT = TIMEOUT_DEFAULT,
    parameter int IDW     = $clog2(NREQ)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [NREQ-1:0]   req_valid_i,
    output logic [NREQ-1:0]   req_ready_o,
    input  logic [NREQ*W-1:0] req_x_i,
    input  logic [NREQ*W-1:0] req_y_i,
    output logic              mul_start_o,
    output logic [W-1:0]      mul_x_o,
    output logic [W-1:0]      mul_y_o,
    input  logic              mul_done_i,
    input  logic [2*W-1:0]    mul_out_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [IDW-1:0]    rsp_id_o,
    output logic [2*W-1:0]    rsp_data_o,
    output logic              rsp_err_o
);

    localparam int CW = $clog2(TIMEOUT + 1);

    state_e         state_q, state_d;
    logic [IDW-1:0] ptr_q, ptr_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           mul_start_q, mul_start_d;
    logic [W-1:0]   mul_x_q, mul_x_d;
    logic [W-1:0]   mul_y_q, mul_y_d;
    logic           rsp_valid_q, rsp_valid_d;
    logic [IDW-1:0] rsp_id_q, rsp_id_d;
    logic [2*W-1:0] rsp_data_q, rsp_data_d;
    logic           rsp_err_q, rsp_err_d;

    logic [NREQ-1:0] arb_gnt;
    logic [IDW-1:0]  arb_idx;
    logic            arb_vld;

    rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_rr (
        .req_i (req_valid_i),
        .ptr_i (ptr_q),
        .gnt_o (arb_gnt),
        .idx_o (arb_idx),
        .vld_o (arb_vld)
    );

    // Gated by reset so every output reads zero while reset is held.
    assign req_ready_o = (rst_ni && state_q == ST_IDLE) ? arb_gnt : '0;

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        cnt_d       = cnt_q;
        mul_start_d = 1'b0;
        mul_x_d     = mul_x_q;
        mul_y_d     = mul_y_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_data_d  = rsp_data_q;
        rsp_err_d   = rsp_err_q;
        case (state_q)
            ST_IDLE: begin
                if (arb_vld) begin
                    mul_x_d     = req_x_i[arb_idx*W +: W];
                    mul_y_d     = req_y_i[arb_idx*W +: W];
                    rsp_id_d    = arb_idx;
                    ptr_d       = (arb_idx == IDW'(NREQ - 1)) ? '0 : arb_idx + 1'b1;
                    mul_start_d = 1'b1;
                    state_d     = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                cnt_d   = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                cnt_d = cnt_q + 1'b1;
                // A done arriving on the final watchdog cycle still counts as success.
                if (mul_done_i) begin
                    rsp_data_d  = mul_out_i;
                    rsp_err_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    state_d     = ST_RESP;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    rsp_data_d  = '0;
                    rsp_err_d   = 1'b1;
                    rsp_valid_d = 1'b1;
                    state_d     = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready_i) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            cnt_q       <= '0;
            mul_start_q <= 1'b0;
            mul_x_q     <= '0;
            mul_y_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            cnt_q       <= cnt_d;
            mul_start_q <= mul_start_d;
            mul_x_q     <= mul_x_d;
            mul_y_q     <= mul_y_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign mul_start_o = mul_start_q;
    assign mul_x_o     = mul_x_q;
    assign mul_y_o     = mul_y_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_id_o    = rsp_id_q;
    assign rsp_data_o  = rsp_data_q;
    assign rsp_err_o   = rsp_err_q;

endmodule

// File: tb/tb_booth_mul_arbiter.sv
// Directed bench for booth_mul_arbiter with a latency-programmable multiplier model.
// Latency: model asserts done L cycles after the start pulse.
// Backpressure: rsp_ready driven per scenario.
module tb_booth_mul_arbiter;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;
    logic [3:0]  req_valid = '0;
    logic [3:0]  req_ready;
    logic [63:0] req_x = '0;
    logic [63:0] req_y = '0;
    logic        mul_start;
    logic [15:0] mul_x, mul_y;
    logic        mul_done = 1'b0;
    logic [31:0] mul_out  = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [1:0]  rsp_id;
    logic [31:0] rsp_data;
    logic        rsp_err;

    int tests_run    = 0;
    int tests_failed = 0;
    int cyc          = 0;

    int                 mdl_lat   = 8;
    bit                 mdl_mute  = 1'b0;
    int                 late_req  = 0;
    int                 late_seen = 0;
    int                 cd        = 0;
    logic signed [31:0] prod      = '0;

    booth_mul_arbiter #(
        .NREQ    (4),
        .W       (16),
        .TIMEOUT (32)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_x_i     (req_x),
        .req_y_i     (req_y),
        .mul_start_o (mul_start),
        .mul_x_o     (mul_x),
        .mul_y_o     (mul_y),
        .mul_done_i  (mul_done),
        .mul_out_i   (mul_out),
        .rsp_valid_o (rsp_valid),
        .rsp_ready_i (rsp_ready),
        .rsp_id_o    (rsp_id),
        .rsp_data_o  (rsp_data),
        .rsp_err_o   (rsp_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Multiplier model: done lands in cycle start+L; late_req forces a stray done pulse.
    always @(negedge clk) begin
        mul_done = 1'b0;
        if (late_req != late_seen) begin
            late_seen = late_req;
            mul_done  = 1'b1;
        end
        if (mul_start) begin
            cd   = mdl_lat;
            prod = $signed(mul_x) * $signed(mul_y);
        end else if (cd > 0) begin
            cd--;
            if (cd == 0 && !mdl_mute) begin
                mul_done = 1'b1;
                mul_out  = prod;
            end
        end
    end

    task automatic accept(input int r, input logic [15:0] x, input logic [15:0] y, output int t0);
        bit got = 1'b0;
        t0 = -1;
        @(negedge clk);
        req_x[r*16 +: 16] = x;
        req_y[r*16 +: 16] = y;
        req_valid[r]      = 1'b1;
        for (int i = 0; i < 60 && !got; i++) begin
            #1;
            if (req_ready[r]) begin
                got = 1'b1;
                t0  = cyc;
            end
            @(negedge clk);
        end
        req_valid[r] = 1'b0;
        if (!got) begin
            tests_run++;
            tests_failed++;
            $display("FAIL accept_bound: requester %0d saw no req_ready in 60 cycles, expected a grant", r);
        end
    endtask

    task automatic wait_rsp(output int t);
        t = -1;
        for (int i = 0; i < 120; i++) begin
            if (rsp_valid) begin
                t = cyc;
                break;
            end
            @(negedge clk);
        end
        if (t < 0) begin
            tests_run++;
            tests_failed++;
            $display("FAIL rsp_bound: rsp_valid never rose in 120 cycles, expected a response");
        end
    endtask

    task automatic test_reset();
        #2;
        rst_n     = 1'b0;
        req_valid = 4'hF;
        repeat (3) @(negedge clk);
        #1;
        tests_run++;
        if (req_ready !== 4'h0) begin tests_failed++; $display("FAIL reset_req_ready: got %h expected 0", req_ready); end
        tests_run++;
        if (mul_start !== 1'b0) begin tests_failed++; $display("FAIL reset_mul_start: got %b expected 0", mul_start); end
        tests_run++;
        if ({mul_x, mul_y} !== 32'h0) begin tests_failed++; $display("FAIL reset_operands: got %h/%h expected 0/0", mul_x, mul_y); end
        tests_run++;
        if ({rsp_valid, rsp_id, rsp_data, rsp_err} !== 36'h0) begin
            tests_failed++;
            $display("FAIL reset_rsp: got v=%b id=%0d d=%h e=%b expected all 0", rsp_valid, rsp_id, rsp_data, rsp_err);
        end
        req_valid = '0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_fairness();
        logic [3:0]  exp_g [9] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h1, 4'h4, 4'h8, 4'h1, 4'h4};
        logic [15:0] exp_x [9] = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd1, 16'd3, 16'd4, 16'd1, 16'd3};
        logic [3:0]  g;
        int          t;
        mdl_lat = 2;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            req_x[i*16 +: 16] = 16'(i + 1);
            req_y[i*16 +: 16] = 16'h0010;
        end
        req_valid = 4'hF;
        for (int k = 0; k < 9; k++) begin
            if (k == 5) req_valid = 4'b1101;
            g = '0;
            for (int i = 0; i < 40; i++) begin
                #1;
                if (req_ready != 4'h0) begin
                    g = req_ready;
                    break;
                end
                @(negedge clk);
            end
            tests_run++;
            if (g !== exp_g[k]) begin tests_failed++; $display("FAIL fair_grant[%0d]: got %b expected %b", k, g, exp_g[k]); end
            @(negedge clk);
            tests_run++;
            if (mul_x !== exp_x[k]) begin tests_failed++; $display("FAIL fair_mul_x[%0d]: got %h expected %h", k, mul_x, exp_x[k]); end
        end
        req_valid = '0;
        wait_rsp(t);
        tests_run++;
        if (rsp_id !== 2'd2 || rsp_data !== 32'h30) begin
            tests_failed++;
            $display("FAIL fair_last_rsp: got id=%0d d=%h expected id=2 d=00000030", rsp_id, rsp_data);
        end
        @(negedge clk);
    endtask

    task automatic test_single();
        int t0, t;
        mdl_lat = 8;
        accept(2, 16'h0003, 16'h0004, t0);
        #1;
        tests_run++;
        if (mul_start !== 1'b1) begin tests_failed++; $display("FAIL single_start: got %b expected 1 at T0+1", mul_start); end
        tests_run++;
        if (mul_x !== 16'h0003 || mul_y !== 16'h0004) begin tests_failed++; $display("FAIL single_ops: got %h/%h expected 0003/0004", mul_x, mul_y); end
        @(negedge clk);
        tests_run++;
        if (mul_start !== 1'b0) begin tests_failed++; $display("FAIL single_start_pulse: got %b expected 0 at T0+2", mul_start); end
        wait_rsp(t);
        tests_run++;
        if (t - t0 !== 10) begin tests_failed++; $display("FAIL single_latency: got T0+%0d expected T0+10", t - t0); end
        tests_run++;
        if (rsp_id !== 2'd2 || rsp_data !== 32'h0000000C || rsp_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL single_rsp: got id=%0d d=%h e=%b expected id=2 d=0000000c e=0", rsp_id, rsp_data, rsp_err);
        end
        @(negedge clk);
    endtask

    task automatic test_signed();
        int t0, t;
        accept(1, 16'hFFFD, 16'h0004, t0);
        #1;
        tests_run++;
        if (mul_x !== 16'hFFFD || mul_y !== 16'h0004) begin tests_failed++; $display("FAIL signed_ops: got %h/%h expected fffd/0004", mul_x, mul_y); end
        wait_rsp(t);
        tests_run++;
        if (rsp_id !== 2'd1 || rsp_data !== 32'hFFFFFFF4 || rsp_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL signed_rsp: got id=%0d d=%h e=%b expected id=1 d=fffffff4 e=0", rsp_id, rsp_data, rsp_err);
        end
        @(negedge clk);
    endtask

    task automatic test_timeout();
        int t0, t;
        bit quiet = 1'b1;
        mdl_mute = 1'b1;
        accept(3, 16'h1234, 16'h0002, t0);
        wait_rsp(t);
        tests_run++;
        if (t - t0 !== 34) begin tests_failed++; $display("FAIL timeout_latency: got T0+%0d expected T0+34", t - t0); end
        tests_run++;
        if (rsp_err !== 1'b1 || rsp_data !== 32'h0 || rsp_id !== 2'd3) begin
            tests_failed++;
            $display("FAIL timeout_rsp: got id=%0d d=%h e=%b expected id=3 d=0 e=1", rsp_id, rsp_data, rsp_err);
        end
        @(negedge clk);
        late_req++;
        repeat (10) begin
            @(negedge clk);
            if (rsp_valid || mul_start) quiet = 1'b0;
        end
        tests_run++;
        if (!quiet) begin tests_failed++; $display("FAIL timeout_late_done: got activity after late done, expected none"); end
        mdl_mute = 1'b0;
    endtask

    task automatic test_backpressure();
        int         t0, t;
        logic [3:0] g = '0;
        mdl_lat   = 3;
        rsp_ready = 1'b0;
        accept(0, 16'h0005, 16'h0006, t0);
        wait_rsp(t);
        tests_run++;
        if (t - t0 !== 5) begin tests_failed++; $display("FAIL bp_latency: got T0+%0d expected T0+5", t - t0); end
        req_valid = 4'b1110;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            #1;
            tests_run++;
            if ({rsp_valid, rsp_id, rsp_data, rsp_err, req_ready, mul_start} !== {1'b1, 2'd0, 32'h1E, 1'b0, 4'h0, 1'b0}) begin
                tests_failed++;
                $display("FAIL bp_hold[%0d]: got v=%b id=%0d d=%h e=%b rdy=%b st=%b expected v=1 id=0 d=0000001e e=0 rdy=0000 st=0",
                         i, rsp_valid, rsp_id, rsp_data, rsp_err, req_ready, mul_start);
            end
        end
        rsp_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            #1;
            if (req_ready != 4'h0) begin
                g = req_ready;
                break;
            end
        end
        tests_run++;
        if (g !== 4'b0010) begin tests_failed++; $display("FAIL bp_next_grant: got %b expected 0010", g); end
        @(negedge clk);
        req_valid = '0;
        wait_rsp(t);
        @(negedge clk);
    endtask

    task automatic test_reset_mid_wait();
        int         t0, t;
        bit         quiet = 1'b1;
        logic [3:0] g     = '0;
        mdl_lat = 20;
        accept(2, 16'h0007, 16'h0003, t0);
        repeat (5) @(negedge clk);
        req_valid = 4'hF;
        rst_n     = 1'b0;
        #1;
        tests_run++;
        if ({req_ready, mul_start, mul_x, mul_y} !== 37'h0) begin
            tests_failed++;
            $display("FAIL rstw_req_mul: got rdy=%b st=%b x=%h y=%h expected all 0", req_ready, mul_start, mul_x, mul_y);
        end
        tests_run++;
        if ({rsp_valid, rsp_id, rsp_data, rsp_err} !== 36'h0) begin
            tests_failed++;
            $display("FAIL rstw_rsp: got v=%b id=%0d d=%h e=%b expected all 0", rsp_valid, rsp_id, rsp_data, rsp_err);
        end
        repeat (3) @(negedge clk);
        req_valid = '0;
        mdl_lat   = 4;
        rst_n     = 1'b1;
        repeat (25) begin
            @(negedge clk);
            if (rsp_valid || mul_start) quiet = 1'b0;
        end
        tests_run++;
        if (!quiet) begin tests_failed++; $display("FAIL rstw_stale: got activity after reset, expected none"); end
        req_x[15:0] = 16'h0009;
        req_y[15:0] = 16'h0002;
        req_valid   = 4'hF;
        t0          = -1;
        for (int i = 0; i < 10; i++) begin
            #1;
            if (req_ready != 4'h0) begin
                g  = req_ready;
                t0 = cyc;
                break;
            end
            @(negedge clk);
        end
        tests_run++;
        if (g !== 4'b0001) begin tests_failed++; $display("FAIL rstw_first_grant: got %b expected 0001", g); end
        @(negedge clk);
        req_valid = '0;
        wait_rsp(t);
        tests_run++;
        if (t - t0 !== 6 || rsp_id !== 2'd0 || rsp_data !== 32'h12) begin
            tests_failed++;
            $display("FAIL rstw_rsp_after: got T0+%0d id=%0d d=%h expected T0+6 id=0 d=00000012", t - t0, rsp_id, rsp_data);
        end
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_fairness();
        test_single();
        test_signed();
        test_timeout();
        test_backpressure();
        test_reset_mid_wait();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
